// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants, also used by the exception unit.
package if_pkg;

    localparam logic [1:0] INST_SIZE_WORD = 2'd2;
    localparam logic [4:0] EXC_ADEL       = 5'h04;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with clear and same-cycle push/pop. A push into a full
// FIFO is taken only when a pop happens in the same cycle.
module if_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues pc-stage addresses on the SRAM-like bus, buffers
// returned words in issue order and drops stale fetches after a redirect.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int OUT_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pc_valid,
    input  logic [31:0] pc_addr,
    output logic        pc_ready,
    input  logic        flush,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel
);

    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int OBW = $clog2(OUT_DEPTH + 1);
    localparam int SW  = $clog2(OUT_DEPTH + MAX_OUTSTANDING + 1) + 1;

    logic [OCW-1:0] out_cnt_q, out_cnt_d;
    logic [OCW-1:0] discard_cnt_q, discard_cnt_d;
    logic [OCW-1:0] tag_count;
    logic [OBW-1:0] ob_count;
    logic [SW-1:0]  occupancy;
    logic [31:0]    tag_rdata;
    fetch_entry_t   ob_wdata, ob_rdata;
    logic           id_pop, credit, aligned, accept, mis_accept;
    logic           resp, drop, keep, ob_push;

    always_comb begin
        id_pop = id_valid && id_ready;
        // Every issued request will need a buffer slot, including ones that
        // will be discarded; a head leaving this cycle frees its slot.
        occupancy  = SW'(out_cnt_q) + SW'(ob_count) - SW'(id_pop);
        credit     = (occupancy < SW'(OUT_DEPTH)) && (out_cnt_q < OCW'(MAX_OUTSTANDING));
        aligned    = (pc_addr[1:0] == 2'b00);
        inst_req   = resetn && pc_valid && !flush && credit && aligned;
        accept     = inst_req && inst_addr_ok;
        mis_accept = resetn && pc_valid && !flush && !aligned && (out_cnt_q == '0)
                     && (occupancy < SW'(OUT_DEPTH));
        pc_ready   = accept || mis_accept;

        resp = inst_data_ok && (out_cnt_q != '0);
        drop = resp && (flush || (discard_cnt_q != '0));
        keep = resp && !drop;

        ob_push = keep || mis_accept;
        if (mis_accept) begin
            ob_wdata = '{pc: pc_addr, inst: 32'd0, adel: 1'b1};
        end else begin
            ob_wdata = '{pc: tag_rdata, inst: inst_rdata, adel: 1'b0};
        end

        out_cnt_d = out_cnt_q + OCW'(accept) - OCW'(resp);
        // After a redirect every request still on the bus is stale.
        if (flush) begin
            discard_cnt_d = out_cnt_q - OCW'(resp);
        end else if (drop) begin
            discard_cnt_d = discard_cnt_q - 1'b1;
        end else begin
            discard_cnt_d = discard_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_cnt_q     <= '0;
            discard_cnt_q <= '0;
        end else begin
            out_cnt_q     <= out_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    if_sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .clear (flush),
        .push  (accept),
        .wdata (pc_addr),
        .pop   (keep),
        .rdata (tag_rdata),
        .count (tag_count)
    );

    if_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(OUT_DEPTH)) u_out_buf (
        .clk   (clk),
        .rst_n (resetn),
        .clear (flush),
        .push  (ob_push),
        .wdata (ob_wdata),
        .pop   (id_pop),
        .rdata (ob_rdata),
        .count (ob_count)
    );

    assign id_valid   = (ob_count != '0);
    assign id_pc      = id_valid ? ob_rdata.pc : 32'd0;
    assign id_inst    = id_valid ? ob_rdata.inst : 32'd0;
    assign id_adel    = id_valid && ob_rdata.adel;
    assign inst_wr    = 1'b0;
    assign inst_size  = INST_SIZE_WORD;
    assign inst_addr  = pc_addr;
    assign inst_wdata = 32'd0;

    a_no_orphan_data: assert property (@(posedge clk) disable iff (!resetn)
        inst_data_ok |-> (out_cnt_q != '0));
    a_tag_tracks_live: assert property (@(posedge clk) disable iff (!resetn)
        tag_count == (out_cnt_q - discard_cnt_q));

endmodule
